// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: ID-stage forwarding selects, stall/flush
// sequencing for branches and load-use, a memory-busy hold and saturating event counters.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic                      IF_ID_use_rs1,
  input  logic                      IF_ID_use_rs2,
  input  logic                      IF_ID_is_branch,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      ID_EX_reg_wr_en,
  input  logic                      ID_EX_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
  input  logic                      EX_MEM_reg_wr_en,
  input  logic                      EX_MEM_mem_read,
  input  logic                      pc_sel,
  input  logic                      mem_busy,
  input  logic                      cnt_clr,
  output logic [1:0]                forward_comp1,
  output logic [1:0]                forward_comp2,
  output logic                      pc_write_en,
  output logic                      IF_ID_write_en,
  output logic                      ID_EX_bubble,
  output logic                      IF_ID_flush,
  output logic [CNT_WIDTH-1:0]      stall_count,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  typedef enum logic [1:0] {RUN, STALL, HOLD} state_e;

  state_e               state_q, state_d;
  state_e               saved_state_q, saved_state_d;
  logic [1:0]           remain_q, remain_d;
  logic [1:0]           saved_remain_q, saved_remain_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic ex_mem_dep1, ex_mem_dep2;
  logic id_ex_dep1, id_ex_dep2, id_ex_dep;
  logic [1:0] stall_need;

  // x0 never carries a result, so a match on register 0 is not a dependency.
  assign ex_mem_dep1 = EX_MEM_reg_wr_en && (EX_MEM_rd != '0) && IF_ID_use_rs1 && (EX_MEM_rd == IF_ID_rs1);
  assign ex_mem_dep2 = EX_MEM_reg_wr_en && (EX_MEM_rd != '0) && IF_ID_use_rs2 && (EX_MEM_rd == IF_ID_rs2);
  assign id_ex_dep1  = ID_EX_reg_wr_en && (ID_EX_rd != '0) && IF_ID_use_rs1 && (ID_EX_rd == IF_ID_rs1);
  assign id_ex_dep2  = ID_EX_reg_wr_en && (ID_EX_rd != '0) && IF_ID_use_rs2 && (ID_EX_rd == IF_ID_rs2);
  assign id_ex_dep   = id_ex_dep1 || id_ex_dep2;

  always_comb begin
    stall_need = 2'd0;
    if (IF_ID_is_branch && id_ex_dep) begin
      stall_need = ID_EX_mem_read ? 2'd2 : 2'd1;
    end else if (!IF_ID_is_branch && ID_EX_mem_read && id_ex_dep) begin
      stall_need = 2'd1;
    end
  end

  always_comb begin
    forward_comp1 = 2'b00;
    forward_comp2 = 2'b00;
    if (!reset && ex_mem_dep1) forward_comp1 = EX_MEM_mem_read ? 2'b10 : 2'b01;
    if (!reset && ex_mem_dep2) forward_comp2 = EX_MEM_mem_read ? 2'b10 : 2'b01;
  end

  // Priority: reset, then memory hold, then stall, then flush.
  always_comb begin
    pc_write_en    = 1'b1;
    IF_ID_write_en = 1'b1;
    ID_EX_bubble   = 1'b0;
    IF_ID_flush    = 1'b0;
    state_d        = state_q;
    remain_d       = remain_q;
    saved_state_d  = saved_state_q;
    saved_remain_d = saved_remain_q;
    if (reset) begin
      state_d = RUN;
    end else if (mem_busy || state_q == HOLD) begin
      pc_write_en    = 1'b0;
      IF_ID_write_en = 1'b0;
      if (mem_busy) begin
        if (state_q != HOLD) begin
          saved_state_d  = state_q;
          saved_remain_d = remain_q;
        end
        state_d = HOLD;
      end else begin
        state_d  = saved_state_q;
        remain_d = saved_remain_q;
      end
    end else if (state_q == STALL) begin
      pc_write_en    = 1'b0;
      IF_ID_write_en = 1'b0;
      ID_EX_bubble   = 1'b1;
      remain_d       = remain_q - 2'd1;
      if (remain_d == 2'd0) state_d = RUN;
    end else begin
      if (stall_need != 2'd0) begin
        pc_write_en    = 1'b0;
        IF_ID_write_en = 1'b0;
        ID_EX_bubble   = 1'b1;
        if (stall_need == 2'd2) begin
          state_d  = STALL;
          remain_d = stall_need - 2'd1;
        end
      end else if (pc_sel) begin
        IF_ID_flush = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (ID_EX_bubble && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (IF_ID_flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      remain_q       <= 2'd0;
      saved_state_q  <= RUN;
      saved_remain_q <= 2'd0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      remain_q       <= remain_d;
      saved_state_q  <= saved_state_d;
      saved_remain_q <= saved_remain_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl: a driver pushes the reference model's
// expected outputs into a queue, and a monitor pops and compares them each cycle.
module tb_hazard_ctrl;

  localparam int RW      = 5;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [RW-1:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd, EX_MEM_rd;
  logic          IF_ID_use_rs1, IF_ID_use_rs2, IF_ID_is_branch;
  logic          ID_EX_reg_wr_en, ID_EX_mem_read, EX_MEM_reg_wr_en, EX_MEM_mem_read;
  logic          pc_sel, mem_busy, cnt_clr;
  logic [1:0]    forward_comp1, forward_comp2;
  logic          pc_write_en, IF_ID_write_en, ID_EX_bubble, IF_ID_flush;
  logic [CW-1:0] stall_count, flush_count;

  hazard_ctrl #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
    .IF_ID_is_branch(IF_ID_is_branch),
    .ID_EX_rd(ID_EX_rd), .ID_EX_reg_wr_en(ID_EX_reg_wr_en), .ID_EX_mem_read(ID_EX_mem_read),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_reg_wr_en(EX_MEM_reg_wr_en), .EX_MEM_mem_read(EX_MEM_mem_read),
    .pc_sel(pc_sel), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .forward_comp1(forward_comp1), .forward_comp2(forward_comp2),
    .pc_write_en(pc_write_en), .IF_ID_write_en(IF_ID_write_en),
    .ID_EX_bubble(ID_EX_bubble), .IF_ID_flush(IF_ID_flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [RW-1:0] rs1, rs2, exRd, memRd;
    logic          use1, use2, isBr, exWr, exLd, memWr, memLd, pcSel, busy, clr;
  } stim_t;

  typedef struct {
    logic [1:0]    f1, f2;
    logic          pcWe, ifWe, bub, fl;
    logic [CW-1:0] sc, fc;
    bit            cntKnown;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: bubbles still owed, and a hold that parks them until memory is ready.
  int owed = 0;
  int heldOwed = 0;
  bit inHold = 0;
  int stallCnt = 0;
  int flushCnt = 0;
  bit cntKnown = 0;

  function automatic bit dep(input logic wr, input logic [RW-1:0] rd,
                             input logic u, input logic [RW-1:0] rs);
    return wr && (rd != 0) && u && (rd == rs);
  endfunction

  function automatic logic [1:0] fwdSel(input stim_t s, input logic u, input logic [RW-1:0] rs);
    if (s.rst) return 2'b00;
    if (dep(s.memWr, s.memRd, u, rs)) return s.memLd ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s = '{rst: 1'b0, rs1: '0, rs2: '0, exRd: '0, memRd: '0, use1: 1'b0, use2: 1'b0,
          isBr: 1'b0, exWr: 1'b0, exLd: 1'b0, memWr: 1'b0, memLd: 1'b0,
          pcSel: 1'b0, busy: 1'b0, clr: 1'b0};
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    int   need;
    bit   anyDep;
    @(posedge clk);
    #2;
    reset = s.rst; IF_ID_rs1 = s.rs1; IF_ID_rs2 = s.rs2;
    IF_ID_use_rs1 = s.use1; IF_ID_use_rs2 = s.use2; IF_ID_is_branch = s.isBr;
    ID_EX_rd = s.exRd; ID_EX_reg_wr_en = s.exWr; ID_EX_mem_read = s.exLd;
    EX_MEM_rd = s.memRd; EX_MEM_reg_wr_en = s.memWr; EX_MEM_mem_read = s.memLd;
    pc_sel = s.pcSel; mem_busy = s.busy; cnt_clr = s.clr;

    e.f1 = fwdSel(s, s.use1, s.rs1);
    e.f2 = fwdSel(s, s.use2, s.rs2);
    e.pcWe = 1'b1; e.ifWe = 1'b1; e.bub = 1'b0; e.fl = 1'b0;
    e.sc = CW'(stallCnt); e.fc = CW'(flushCnt); e.cntKnown = cntKnown;

    anyDep = dep(s.exWr, s.exRd, s.use1, s.rs1) || dep(s.exWr, s.exRd, s.use2, s.rs2);
    need = 0;
    if (s.isBr && anyDep) need = s.exLd ? 2 : 1;
    else if (s.exLd && anyDep) need = 1;

    if (s.rst) begin
      owed = 0; inHold = 0; heldOwed = 0;
    end else if (s.busy || inHold) begin
      e.pcWe = 1'b0; e.ifWe = 1'b0;
      if (s.busy) begin
        if (!inHold) heldOwed = owed;
        inHold = 1;
      end else begin
        inHold = 0;
        owed = heldOwed;
      end
    end else if (owed > 0) begin
      e.pcWe = 1'b0; e.ifWe = 1'b0; e.bub = 1'b1;
      owed--;
    end else if (need > 0) begin
      e.pcWe = 1'b0; e.ifWe = 1'b0; e.bub = 1'b1;
      owed = need - 1;
    end else if (s.pcSel) begin
      e.fl = 1'b1;
    end
    expQ.push_back(e);

    if (s.rst) begin
      stallCnt = 0; flushCnt = 0; cntKnown = 1;
    end else if (s.clr) begin
      stallCnt = 0; flushCnt = 0;
    end else begin
      if (e.bub && stallCnt < CNT_MAX) stallCnt++;
      if (e.fl && flushCnt < CNT_MAX) flushCnt++;
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("forward_comp1", 16'(forward_comp1), 16'(e.f1));
        checkOutput("forward_comp2", 16'(forward_comp2), 16'(e.f2));
        checkOutput("pc_write_en", 16'(pc_write_en), 16'(e.pcWe));
        checkOutput("IF_ID_write_en", 16'(IF_ID_write_en), 16'(e.ifWe));
        checkOutput("ID_EX_bubble", 16'(ID_EX_bubble), 16'(e.bub));
        checkOutput("IF_ID_flush", 16'(IF_ID_flush), 16'(e.fl));
        if (e.cntKnown) begin
          checkOutput("stall_count", 16'(stall_count), 16'(e.sc));
          checkOutput("flush_count", 16'(flush_count), 16'(e.fc));
        end
      end
    end
  end

  initial begin : driver
    stim_t s, ldBr, ldInMem;
    int    drainWait;
    reset = 1'b1; IF_ID_rs1 = '0; IF_ID_rs2 = '0; IF_ID_use_rs1 = 1'b0; IF_ID_use_rs2 = 1'b0;
    IF_ID_is_branch = 1'b0; ID_EX_rd = '0; ID_EX_reg_wr_en = 1'b0; ID_EX_mem_read = 1'b0;
    EX_MEM_rd = '0; EX_MEM_reg_wr_en = 1'b0; EX_MEM_mem_read = 1'b0;
    pc_sel = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;

    s = idleStim(); s.rst = 1'b1;
    repeat (2) applyStimulus(s);
    repeat (2) applyStimulus(idleStim());

    ldBr = idleStim();
    ldBr.rs1 = 5'd5; ldBr.rs2 = 5'd0; ldBr.use1 = 1'b1; ldBr.use2 = 1'b1; ldBr.isBr = 1'b1;
    ldBr.exRd = 5'd5; ldBr.exWr = 1'b1; ldBr.exLd = 1'b1;
    ldInMem = idleStim();
    ldInMem.rs1 = 5'd5; ldInMem.use1 = 1'b1; ldInMem.use2 = 1'b1; ldInMem.isBr = 1'b1;
    ldInMem.memRd = 5'd5; ldInMem.memWr = 1'b1; ldInMem.memLd = 1'b1;

    applyStimulus(ldBr);
    repeat (2) applyStimulus(ldInMem);
    applyStimulus(idleStim());

    s = idleStim();
    s.memRd = 5'd3; s.memWr = 1'b1; s.rs1 = 5'd3; s.rs2 = 5'd4;
    s.use1 = 1'b1; s.use2 = 1'b1; s.isBr = 1'b1;
    applyStimulus(s);

    s = idleStim();
    s.exRd = 5'd0; s.exWr = 1'b1; s.exLd = 1'b1; s.rs1 = 5'd0; s.use1 = 1'b1;
    applyStimulus(s);

    s = idleStim(); s.pcSel = 1'b1;
    applyStimulus(s);
    applyStimulus(idleStim());
    applyStimulus(ldBr);
    s = ldInMem; s.pcSel = 1'b1;
    applyStimulus(s);
    applyStimulus(idleStim());

    s = idleStim(); s.clr = 1'b1;
    applyStimulus(s);
    applyStimulus(ldBr);
    s = ldInMem; s.busy = 1'b1;
    repeat (3) applyStimulus(s);
    repeat (3) applyStimulus(ldInMem);
    applyStimulus(idleStim());

    s = idleStim();
    s.exRd = 5'd7; s.exWr = 1'b1; s.exLd = 1'b1; s.rs2 = 5'd7; s.use2 = 1'b1;
    repeat (CNT_MAX + 3) applyStimulus(s);
    s.clr = 1'b1;
    applyStimulus(s);
    applyStimulus(idleStim());

    for (int i = 0; i < 600; i++) begin
      s.rst   = ($urandom_range(0, 63) == 0);
      s.rs1   = RW'($urandom_range(0, 3));
      s.rs2   = RW'($urandom_range(0, 3));
      s.exRd  = RW'($urandom_range(0, 3));
      s.memRd = RW'($urandom_range(0, 3));
      s.use1  = 1'($urandom_range(0, 1));
      s.use2  = 1'($urandom_range(0, 1));
      s.isBr  = 1'($urandom_range(0, 1));
      s.exWr  = 1'($urandom_range(0, 1));
      s.exLd  = 1'($urandom_range(0, 1));
      s.memWr = 1'($urandom_range(0, 1));
      s.memLd = 1'($urandom_range(0, 1));
      s.pcSel = 1'($urandom_range(0, 1));
      s.busy  = ($urandom_range(0, 7) == 0);
      s.clr   = ($urandom_range(0, 31) == 0);
      applyStimulus(s);
    end

    drainWait = 0;
    while (expQ.size() > 0 && drainWait < 10) begin
      @(posedge clk);
      drainWait++;
    end
    @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
